// File: rtl/single_cycle_cpu.sv
// -----------------------------------------------------------------------------
// single_cycle_cpu
//
// 64-bit single-cycle LEGv8 (ARMv8 subset) core. Fetch, decode, execute,
// memory access and writeback all complete within one CLK period (CPI = 1).
// Everything the core needs lives in this file: the instruction ROM holding
// the program image, a 32x64 register file, the ALU, the immediate
// sign-extenders, the main decoder and a small data RAM.
//
// Supported instructions (any other encoding executes as a NOP):
//   LDUR, STUR             Rt <-> Mem[Rn + sext(D9)]
//   ADD, SUB, AND, ORR     Rd = Rn op Rm
//   CBZ                    if (Rt == 0) PC += sext(imm19) << 2
//   B                      PC += sext(imm26) << 2
//   MOVZ                   Rd = imm16 << (16 * hw), other bits zero
//
// Parameters
//   IMEM_WORDS   instruction ROM depth in 32-bit words, indexed by PC[7:2]
//   DMEM_DWORDS  data RAM depth in 64-bit doublewords, indexed by addr[7:3]
//
// Ports
//   CLK          in   1   system clock; all state updates on the rising edge
//   resetl       in   1   asynchronous active-low reset
//   startpc      in   64  PC value loaded (and held) while resetl = 0
//   currentpc    out  64  PC register, address of the executing instruction
//   MemtoRegOut  out  64  writeback value of the current instruction
// -----------------------------------------------------------------------------
module single_cycle_cpu #(
   parameter int IMEM_WORDS  = 64,
   parameter int DMEM_DWORDS = 32
) (
   input  logic        CLK,
   input  logic        resetl,
   input  logic [63:0] startpc,
   output logic [63:0] currentpc,
   output logic [63:0] MemtoRegOut
);

   localparam int IMEM_AW = $clog2(IMEM_WORDS);
   localparam int DMEM_AW = $clog2(DMEM_DWORDS);

   // Major opcode fields
   localparam logic [10:0] OP_LDUR = 11'h7C2;
   localparam logic [10:0] OP_STUR = 11'h7C0;
   localparam logic [10:0] OP_ADD  = 11'h458;
   localparam logic [10:0] OP_SUB  = 11'h658;
   localparam logic [10:0] OP_AND  = 11'h450;
   localparam logic [10:0] OP_ORR  = 11'h550;
   localparam logic [7:0]  OP_CBZ  = 8'hB4;
   localparam logic [5:0]  OP_B    = 6'h05;
   localparam logic [8:0]  OP_MOVZ = 9'h1A5;

   localparam logic [4:0]  XZR     = 5'd31;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_ORR,
      ALU_PASSB
   } alu_op_t;

   // --------------------------------------------------------------------------
   // Instruction ROM: program image.
   //   Program 1 (0x00-0x2C): load 0xA / 0x5, CBZ on XZR skipping two words,
   //   ORR/AND/ADD/SUB, a taken CBZ on a zero result, store 0xF to 0x28.
   //   Program 2 (0x30-0x5C): reload 0xF, assemble 0x123456789ABCDEF0 with
   //   MOVZ/ORR, attempt a write to XZR and read it back, store the constant
   //   to 0x30 and load it back.
   //   0x60-0x64: reload the constant, then B -1 spins between 0x60 and 0x64.
   // --------------------------------------------------------------------------
   function automatic logic [31:0] rom_word(input logic [31:0] idx);
      logic [31:0] w;
      w = 32'h0000_0000;
      case (idx)
         32'd0:  w = 32'hF84083E1; // 0x00 LDUR X1, [X31, #0x08]
         32'd1:  w = 32'hF84103E2; // 0x04 LDUR X2, [X31, #0x10]
         32'd2:  w = 32'hB400007F; // 0x08 CBZ  X31, #3  -> 0x14
         32'd3:  w = 32'hD28175A3; // 0x0C MOVZ X3, #0xBAD (skipped)
         32'd4:  w = 32'hD28175A4; // 0x10 MOVZ X4, #0xBAD (skipped)
         32'd5:  w = 32'hAA020023; // 0x14 ORR  X3, X1, X2
         32'd6:  w = 32'h8A020024; // 0x18 AND  X4, X1, X2
         32'd7:  w = 32'h8B020025; // 0x1C ADD  X5, X1, X2
         32'd8:  w = 32'hCB020026; // 0x20 SUB  X6, X1, X2
         32'd9:  w = 32'hB4000044; // 0x24 CBZ  X4, #2  -> 0x2C
         32'd10: w = 32'hD28175A5; // 0x28 MOVZ X5, #0xBAD (skipped)
         32'd11: w = 32'hF80283E5; // 0x2C STUR X5, [X31, #0x28]
         32'd12: w = 32'hF84283E7; // 0x30 LDUR X7, [X31, #0x28]
         32'd13: w = 32'hD2E24694; // 0x34 MOVZ X20, #0x1234, LSL #48
         32'd14: w = 32'hD2CACF15; // 0x38 MOVZ X21, #0x5678, LSL #32
         32'd15: w = 32'hAA150294; // 0x3C ORR  X20, X20, X21
         32'd16: w = 32'hD2B35795; // 0x40 MOVZ X21, #0x9ABC, LSL #16
         32'd17: w = 32'hAA150294; // 0x44 ORR  X20, X20, X21
         32'd18: w = 32'hD29BDE15; // 0x48 MOVZ X21, #0xDEF0
         32'd19: w = 32'hAA150294; // 0x4C ORR  X20, X20, X21
         32'd20: w = 32'hD29FFFFF; // 0x50 MOVZ X31, #0xFFFF (discarded)
         32'd21: w = 32'hAA1F03F6; // 0x54 ORR  X22, X31, X31
         32'd22: w = 32'hF80303F4; // 0x58 STUR X20, [X31, #0x30]
         32'd23: w = 32'hF84303F7; // 0x5C LDUR X23, [X31, #0x30]
         32'd24: w = 32'hF84303F8; // 0x60 LDUR X24, [X31, #0x30]
         32'd25: w = 32'h17FFFFFF; // 0x64 B    #-1 -> 0x60
         default: w = 32'h0000_0000;
      endcase
      return w;
   endfunction

   // --------------------------------------------------------------------------
   // Program counter
   // --------------------------------------------------------------------------
   logic [63:0] pc;
   logic [63:0] next_pc;

   // While resetl is low the PC is forced to startpc; it follows startpc on
   // each edge so a new start address can be set up during reset.
   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         pc <= startpc;
      end else begin
         pc <= next_pc;
      end
   end

   assign currentpc = pc;

   // --------------------------------------------------------------------------
   // Fetch
   // --------------------------------------------------------------------------
   logic [IMEM_AW-1:0] imem_idx;
   logic [31:0]        instr;

   assign imem_idx = pc[IMEM_AW+1:2];
   assign instr    = rom_word(32'(imem_idx));

   // Instruction fields
   logic [4:0]  rn;
   logic [4:0]  rm;
   logic [4:0]  rt_rd;
   logic [8:0]  d9;
   logic [18:0] imm19;
   logic [25:0] imm26;
   logic [15:0] imm16;
   logic [1:0]  hw;

   assign rn    = instr[9:5];
   assign rm    = instr[20:16];
   assign rt_rd = instr[4:0];
   assign d9    = instr[20:12];
   assign imm19 = instr[23:5];
   assign imm26 = instr[25:0];
   assign imm16 = instr[20:5];
   assign hw    = instr[22:21];

   // --------------------------------------------------------------------------
   // Main decoder
   // --------------------------------------------------------------------------
   logic    reg2loc;      // read port 2 addresses Rt instead of Rm
   logic    alu_src;      // ALU B operand is sext(D9) instead of register
   logic    mem_to_reg;   // writeback from data RAM
   logic    reg_write;
   logic    mem_write;
   logic    cbz_branch;
   logic    uncond_branch;
   logic    movz_sel;     // writeback is the MOVZ immediate
   alu_op_t alu_op;

   always_comb begin
      reg2loc       = 1'b0;
      alu_src       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      mem_write     = 1'b0;
      cbz_branch    = 1'b0;
      uncond_branch = 1'b0;
      movz_sel      = 1'b0;
      alu_op        = ALU_ADD;

      if (instr[31:21] == OP_LDUR) begin
         alu_src    = 1'b1;
         mem_to_reg = 1'b1;
         reg_write  = 1'b1;
      end else if (instr[31:21] == OP_STUR) begin
         reg2loc    = 1'b1;
         alu_src    = 1'b1;
         mem_write  = 1'b1;
      end else if (instr[31:21] == OP_ADD) begin
         reg_write  = 1'b1;
      end else if (instr[31:21] == OP_SUB) begin
         reg_write  = 1'b1;
         alu_op     = ALU_SUB;
      end else if (instr[31:21] == OP_AND) begin
         reg_write  = 1'b1;
         alu_op     = ALU_AND;
      end else if (instr[31:21] == OP_ORR) begin
         reg_write  = 1'b1;
         alu_op     = ALU_ORR;
      end else if (instr[31:24] == OP_CBZ) begin
         reg2loc    = 1'b1;
         cbz_branch = 1'b1;
         alu_op     = ALU_PASSB;
      end else if (instr[31:26] == OP_B) begin
         uncond_branch = 1'b1;
         reg2loc       = 1'b1;
         alu_op        = ALU_PASSB;
      end else if (instr[31:23] == OP_MOVZ) begin
         reg_write  = 1'b1;
         movz_sel   = 1'b1;
      end
   end

   // --------------------------------------------------------------------------
   // Register file: 32 x 64, X31 reads as zero and ignores writes.
   // Reads are combinational and see the pre-edge contents.
   // --------------------------------------------------------------------------
   logic [63:0] regs [32];
   logic [4:0]  rd_addr2;
   logic [63:0] rd1;
   logic [63:0] rd2;

   assign rd_addr2 = reg2loc ? rt_rd : rm;
   assign rd1      = (rn == XZR)       ? 64'd0 : regs[rn];
   assign rd2      = (rd_addr2 == XZR) ? 64'd0 : regs[rd_addr2];

   // --------------------------------------------------------------------------
   // Immediates and ALU
   // --------------------------------------------------------------------------
   logic [63:0] d9_sext;
   logic [63:0] cbz_offset;
   logic [63:0] b_offset;
   logic [63:0] movz_val;
   logic [63:0] alu_b;
   logic [63:0] alu_result;
   logic        alu_zero;

   assign d9_sext    = {{55{d9[8]}}, d9};
   assign cbz_offset = {{43{imm19[18]}}, imm19, 2'b00};
   assign b_offset   = {{36{imm26[25]}}, imm26, 2'b00};
   assign movz_val   = {48'd0, imm16} << {hw, 4'b0000};

   assign alu_b = alu_src ? d9_sext : rd2;

   always_comb begin
      alu_result = 64'd0;
      case (alu_op)
         ALU_ADD:   alu_result = rd1 + alu_b;
         ALU_SUB:   alu_result = rd1 - alu_b;
         ALU_AND:   alu_result = rd1 & alu_b;
         ALU_ORR:   alu_result = rd1 | alu_b;
         ALU_PASSB: alu_result = alu_b;
         default:   alu_result = 64'd0;
      endcase
   end

   // For CBZ the ALU passes Rt through, so the zero flag tests Rt itself.
   assign alu_zero = (alu_result == 64'd0);

   // --------------------------------------------------------------------------
   // Next PC (64-bit wrap-around)
   // --------------------------------------------------------------------------
   always_comb begin
      next_pc = pc + 64'd4;
      if (uncond_branch) begin
         next_pc = pc + b_offset;
      end else if (cbz_branch && alu_zero) begin
         next_pc = pc + cbz_offset;
      end
   end

   // --------------------------------------------------------------------------
   // Data RAM: combinational read, write on rising edge, addr[2:0] ignored.
   // Contents survive reset; the power-up image is given by the initializer.
   // --------------------------------------------------------------------------
   logic [63:0]        dmem [DMEM_DWORDS] = '{
      0: 64'h0000_0000_0000_0001,
      1: 64'h0000_0000_0000_000A,
      2: 64'h0000_0000_0000_0005,
      3: 64'h0FFB_EA7D_EADB_EEFF,
      default: 64'h0
   };
   logic [DMEM_AW-1:0] dmem_idx;
   logic [63:0]        dmem_rdata;

   assign dmem_idx   = alu_result[DMEM_AW+2:3];
   assign dmem_rdata = dmem[dmem_idx];

   // --------------------------------------------------------------------------
   // Writeback
   // --------------------------------------------------------------------------
   logic [63:0] wb_data;

   always_comb begin
      wb_data = alu_result;
      if (mem_to_reg) begin
         wb_data = dmem_rdata;
      end else if (movz_sel) begin
         wb_data = movz_val;
      end
   end

   assign MemtoRegOut = wb_data;

   // Architectural writes are suppressed while reset is asserted, so holding
   // the core in reset on an arbitrary startpc never commits anything.
   always_ff @(posedge CLK) begin
      if (resetl && reg_write && (rt_rd != XZR)) begin
         regs[rt_rd] <= wb_data;
      end
   end

   always_ff @(posedge CLK) begin
      if (resetl && mem_write) begin
         dmem[dmem_idx] <= rd2;
      end
   end

endmodule

// File: tb/tb_single_cycle_cpu.sv
// -----------------------------------------------------------------------------
// tb_single_cycle_cpu
//
// Bench for single_cycle_cpu. Expected (PC, writeback) pairs are queued as
// each run is set up and popped one per clock while the core executes; DUT
// outputs are sampled on the falling edge, away from the active edge.
// -----------------------------------------------------------------------------
module tb_single_cycle_cpu;

   // ---------------------------------------------------------------- clock/reset
   logic        CLK = 1'b0;
   logic        resetl;
   logic [63:0] startpc;
   logic [63:0] currentpc;
   logic [63:0] MemtoRegOut;

   always #5 CLK = ~CLK;

   single_cycle_cpu dut (
      .CLK         (CLK),
      .resetl      (resetl),
      .startpc     (startpc),
      .currentpc   (currentpc),
      .MemtoRegOut (MemtoRegOut)
   );

   localparam logic [63:0] BIG = 64'h1234_5678_9ABC_DEF0;

   // ---------------------------------------------------------------- scoreboard
   logic [63:0] exp_pc_q[$];
   logic [63:0] exp_q[$];
   logic        exp_chk_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   logic watch_ends = 1'b0;
   logic seen_p1    = 1'b0;
   logic seen_p2    = 1'b0;

   task automatic check_eq(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
      end
   endtask

   task automatic expect_step(input logic [63:0] pc, input logic [63:0] val,
                              input logic chk);
      exp_pc_q.push_back(pc);
      exp_q.push_back(val);
      exp_chk_q.push_back(chk);
   endtask

   // ---------------------------------------------------------------- drivers
   // Put the core in reset at addr, give it one edge, release on a falling edge.
   task automatic start_at(input logic [63:0] addr);
      startpc = addr;
      resetl  = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      resetl  = 1'b1;
   endtask

   // Pops one expected step per clock; caller must be just after a falling edge.
   task automatic drain(input string name);
      int          step;
      logic [63:0] e_pc;
      logic [63:0] e_val;
      logic        e_chk;
      step = 0;
      while (exp_pc_q.size() > 0) begin
         if (step > 0) begin
            @(posedge CLK);
            @(negedge CLK);
         end
         e_pc  = exp_pc_q.pop_front();
         e_val = exp_q.pop_front();
         e_chk = exp_chk_q.pop_front();
         check_eq($sformatf("%s_pc%0d", name, step), currentpc, e_pc);
         if (e_chk) check_eq($sformatf("%s_wb%0d", name, step), MemtoRegOut, e_val);
         if (watch_ends) begin
            if (!seen_p1 && currentpc >= 64'h30) begin
               seen_p1 = 1'b1;
               check_eq("prog1_result", MemtoRegOut, 64'hF);
               check_eq("prog1_under_255", 64'(step < 255), 64'd1);
            end
            if (!seen_p2 && currentpc >= 64'h60) begin
               seen_p2 = 1'b1;
               check_eq("prog2_result", MemtoRegOut, BIG);
            end
         end
         step++;
      end
   endtask

   // ---------------------------------------------------------------- watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- main
   initial begin
      int found;
      resetl  = 1'b1;
      startpc = 64'h0;

      // Asynchronous reset: PC must load with no clock edge in between.
      #2;
      startpc = 64'h30;
      resetl  = 1'b0;
      #1;
      check_eq("async_reset_pc30", currentpc, 64'h30);
      check_eq("reset_wb_dmem28_init", MemtoRegOut, 64'h0);
      #1;
      resetl = 1'b1;
      #3;  // rising edge at t=5 has passed
      check_eq("first_step_pc", currentpc, 64'h34);
      startpc = 64'h0;
      resetl  = 1'b0;
      #1;
      check_eq("async_reset_pc0", currentpc, 64'h0);
      @(negedge CLK);
      @(posedge CLK);
      @(negedge CLK);
      check_eq("reset_hold_pc", currentpc, 64'h0);
      resetl = 1'b1;

      // Program 1 then program 2, with the B loop at the end.
      expect_step(64'h00, 64'hA, 1'b1);
      expect_step(64'h04, 64'h5, 1'b1);
      expect_step(64'h08, 64'h0, 1'b1);
      expect_step(64'h14, 64'hF, 1'b1);   // ORR
      expect_step(64'h18, 64'h0, 1'b1);   // AND
      expect_step(64'h1C, 64'hF, 1'b1);   // ADD
      expect_step(64'h20, 64'h5, 1'b1);   // SUB
      expect_step(64'h24, 64'h0, 1'b1);   // CBZ X4 (taken)
      expect_step(64'h2C, 64'h28, 1'b1);  // STUR: address
      expect_step(64'h30, 64'hF, 1'b1);
      expect_step(64'h34, 64'h1234_0000_0000_0000, 1'b1);
      expect_step(64'h38, 64'h0000_5678_0000_0000, 1'b1);
      expect_step(64'h3C, 64'h1234_5678_0000_0000, 1'b1);
      expect_step(64'h40, 64'h0000_0000_9ABC_0000, 1'b1);
      expect_step(64'h44, 64'h1234_5678_9ABC_0000, 1'b1);
      expect_step(64'h48, 64'h0000_0000_0000_DEF0, 1'b1);
      expect_step(64'h4C, BIG, 1'b1);
      expect_step(64'h50, 64'hFFFF, 1'b1);  // MOVZ X31
      expect_step(64'h54, 64'h0, 1'b1);     // ORR of XZR, XZR
      expect_step(64'h58, 64'h30, 1'b1);
      expect_step(64'h5C, BIG, 1'b1);
      expect_step(64'h60, BIG, 1'b1);
      expect_step(64'h64, 64'h0, 1'b0);
      expect_step(64'h60, BIG, 1'b1);       // B -1
      expect_step(64'h64, 64'h0, 1'b0);
      watch_ends = 1'b1;
      drain("prog");
      watch_ends = 1'b0;
      check_eq("prog1_reached", 64'(seen_p1), 64'd1);
      check_eq("prog2_reached", 64'(seen_p2), 64'd1);

      // Reset in the middle of program 1 at PC 0x18.
      start_at(64'h0);
      found = 0;
      for (int i = 0; i < 40; i++) begin
         if (currentpc == 64'h18) begin
            found = 1;
            break;
         end
         @(posedge CLK);
         @(negedge CLK);
      end
      check_eq("reach_pc18", currentpc, 64'h18);
      if (found != 0) begin
         #1;
         startpc = 64'h0;
         resetl  = 1'b0;
         #1;
         check_eq("midrun_reset_pc", currentpc, 64'h0);
         check_eq("midrun_reset_wb", MemtoRegOut, 64'hA);
      end

      // Data RAM retained across resets: read it through held reset vectors.
      startpc = 64'h5C;
      @(posedge CLK);
      @(negedge CLK);
      check_eq("hold_pc5c", currentpc, 64'h5C);
      check_eq("dmem30_retained", MemtoRegOut, BIG);
      startpc = 64'h30;
      @(posedge CLK);
      @(negedge CLK);
      check_eq("dmem28_retained", MemtoRegOut, 64'hF);

      // Unused ROM words decode as NOPs: straight PC+4.
      start_at(64'h68);
      expect_step(64'h68, 64'h0, 1'b0);
      expect_step(64'h6C, 64'h0, 1'b0);
      expect_step(64'h70, 64'h0, 1'b0);
      drain("nop");

      // PC wraps from the top of the 64-bit space to 0.
      start_at(64'hFFFF_FFFF_FFFF_FFFC);
      expect_step(64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b0);
      expect_step(64'h0, 64'hA, 1'b1);
      expect_step(64'h4, 64'h5, 1'b1);
      drain("wrap");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
